uart_tx_stream_ctrl: RTL and testbench

Parametrised UART transmit controller that streams a software-programmed block of bytes from a synchronous-read memory to the uart_tx FSM, one byte per uart_tx handshake.
- Programmable base address and byte count, set on each start.
- Configurable memory read latency and optional inter-byte gap.
- Watchdog on uart_tx_done, plus abort.
- Sits between the message ROM/RAM and uart_tx; replaces the fixed-length, auto-restarting controller.

---
 rtl/uart_tx_stream_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_uart_tx_stream_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_stream_ctrl
// Description : Streams a programmed block of bytes from a synchronous-read
//               memory into uart_tx, one byte per uart_tx start/done
//               handshake, with read latency, inter-byte gap, watchdog and
//               abort handling.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_stream_ctrl #(
    parameter int ADDR_W         = 4,
    parameter int DATA_W         = 8,
    parameter int MAX_BYTES      = 16,
    parameter int RD_LATENCY     = 1,
    parameter int GAP_CYCLES     = 0,
    parameter int TIMEOUT_CYCLES = 0,
    localparam int CNT_W         = $clog2(MAX_BYTES + 1)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  byte_count,
    input  logic              abort,
    output logic [ADDR_W-1:0] mem_read_addr,
    output logic              mem_read_enable,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic [DATA_W-1:0] uart_tx_data,
    output logic              uart_tx_start,
    input  logic              uart_tx_done,
    output logic              busy,
    output logic [CNT_W-1:0]  bytes_sent,
    output logic              transmission_done,
    output logic              timeout_err
);

    // Counter widths; each counter runs 0..N-1 and needs at least one bit.
    localparam int c_LAT_W = (RD_LATENCY > 1)     ? $clog2(RD_LATENCY)     : 1;
    localparam int c_GAP_W = (GAP_CYCLES > 1)     ? $clog2(GAP_CYCLES)     : 1;
    localparam int c_WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [c_LAT_W-1:0] c_LAT_LAST = c_LAT_W'(RD_LATENCY - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [c_WD_W-1:0]  c_WD_LAST  = c_WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0]   c_MAX_CNT  = CNT_W'(MAX_BYTES);
    localparam bit                 c_GAP_EN   = (GAP_CYCLES > 0);
    localparam bit                 c_WD_EN    = (TIMEOUT_CYCLES > 0);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_LATENCY = 3'd2,
        S_WAIT    = 3'd3,
        S_GAP     = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t              r_state,         w_state_nxt;
    logic [ADDR_W-1:0]   r_base,          w_base_nxt;
    logic [CNT_W-1:0]    r_count,         w_count_nxt;
    logic [CNT_W-1:0]    r_idx,           w_idx_nxt;
    logic [c_LAT_W-1:0]  r_lat,           w_lat_nxt;
    logic [c_GAP_W-1:0]  r_gap,           w_gap_nxt;
    logic [c_WD_W-1:0]   r_wd,            w_wd_nxt;
    logic [ADDR_W-1:0]   r_rd_addr,       w_rd_addr_nxt;
    logic                r_rd_en,         w_rd_en_nxt;
    logic [DATA_W-1:0]   r_tx_data,       w_tx_data_nxt;
    logic                r_tx_start,      w_tx_start_nxt;
    logic                r_busy,          w_busy_nxt;
    logic [CNT_W-1:0]    r_bytes_sent,    w_bytes_sent_nxt;
    logic                r_xfer_done,     w_xfer_done_nxt;
    logic                r_timeout_err,   w_timeout_err_nxt;
    logic [CNT_W-1:0]    w_idx_inc;

    assign w_idx_inc = r_idx + CNT_W'(1);

    // Next-state and next-output logic; read strobe and address are set on
    // the transition into READ so the strobe is high during the READ cycle.
    always_comb begin
        w_state_nxt       = r_state;
        w_base_nxt        = r_base;
        w_count_nxt       = r_count;
        w_idx_nxt         = r_idx;
        w_lat_nxt         = r_lat;
        w_gap_nxt         = r_gap;
        w_wd_nxt          = r_wd;
        w_rd_addr_nxt     = r_rd_addr;
        w_rd_en_nxt       = 1'b0;
        w_tx_data_nxt     = r_tx_data;
        w_tx_start_nxt    = 1'b0;
        w_busy_nxt        = r_busy;
        w_bytes_sent_nxt  = r_bytes_sent;
        w_xfer_done_nxt   = 1'b0;
        w_timeout_err_nxt = r_timeout_err;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_timeout_err_nxt = 1'b0;
                    w_bytes_sent_nxt  = '0;
                    w_idx_nxt         = '0;
                    if (byte_count == '0) begin
                        // Empty transfer: report completion without touching memory.
                        w_state_nxt     = S_DONE;
                        w_xfer_done_nxt = 1'b1;
                    end else begin
                        w_base_nxt    = base_addr;
                        w_count_nxt   = (byte_count > c_MAX_CNT) ? c_MAX_CNT : byte_count;
                        w_busy_nxt    = 1'b1;
                        w_state_nxt   = S_READ;
                        w_rd_en_nxt   = 1'b1;
                        w_rd_addr_nxt = base_addr;
                    end
                end
            end
            S_READ: begin
                w_lat_nxt   = '0;
                w_state_nxt = S_LATENCY;
            end
            S_LATENCY: begin
                if (r_lat == c_LAT_LAST) begin
                    w_tx_data_nxt  = mem_read_data;
                    w_tx_start_nxt = 1'b1;
                    w_wd_nxt       = '0;
                    w_state_nxt    = S_WAIT;
                end else begin
                    w_lat_nxt = r_lat + c_LAT_W'(1);
                end
            end
            S_WAIT: begin
                if (uart_tx_done) begin
                    w_bytes_sent_nxt = r_bytes_sent + CNT_W'(1);
                    w_idx_nxt        = w_idx_inc;
                    if (w_idx_inc == r_count) begin
                        w_state_nxt     = S_DONE;
                        w_xfer_done_nxt = 1'b1;
                        w_busy_nxt      = 1'b0;
                    end else if (c_GAP_EN) begin
                        w_gap_nxt   = '0;
                        w_state_nxt = S_GAP;
                    end else begin
                        w_state_nxt   = S_READ;
                        w_rd_en_nxt   = 1'b1;
                        w_rd_addr_nxt = r_base + ADDR_W'(w_idx_inc);
                    end
                end else if (c_WD_EN && (r_wd == c_WD_LAST)) begin
                    // Watchdog expiry ends the transfer; the stalled byte is not counted.
                    w_timeout_err_nxt = 1'b1;
                    w_state_nxt       = S_DONE;
                    w_xfer_done_nxt   = 1'b1;
                    w_busy_nxt        = 1'b0;
                end else begin
                    w_wd_nxt = r_wd + c_WD_W'(1);
                end
            end
            S_GAP: begin
                if (r_gap == c_GAP_LAST) begin
                    w_state_nxt   = S_READ;
                    w_rd_en_nxt   = 1'b1;
                    w_rd_addr_nxt = r_base + ADDR_W'(r_idx);
                end else begin
                    w_gap_nxt = r_gap + c_GAP_W'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase

        // Abort overrides everything outside IDLE, including a same-cycle done.
        if (abort && (r_state != S_IDLE)) begin
            w_state_nxt       = S_IDLE;
            w_rd_en_nxt       = 1'b0;
            w_tx_start_nxt    = 1'b0;
            w_tx_data_nxt     = r_tx_data;
            w_busy_nxt        = 1'b0;
            w_xfer_done_nxt   = 1'b0;
            w_bytes_sent_nxt  = r_bytes_sent;
            w_idx_nxt         = r_idx;
            w_timeout_err_nxt = r_timeout_err;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state       <= S_IDLE;
            r_base        <= '0;
            r_count       <= '0;
            r_idx         <= '0;
            r_lat         <= '0;
            r_gap         <= '0;
            r_wd          <= '0;
            r_rd_addr     <= '0;
            r_rd_en       <= 1'b0;
            r_tx_data     <= '0;
            r_tx_start    <= 1'b0;
            r_busy        <= 1'b0;
            r_bytes_sent  <= '0;
            r_xfer_done   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_base        <= w_base_nxt;
            r_count       <= w_count_nxt;
            r_idx         <= w_idx_nxt;
            r_lat         <= w_lat_nxt;
            r_gap         <= w_gap_nxt;
            r_wd          <= w_wd_nxt;
            r_rd_addr     <= w_rd_addr_nxt;
            r_rd_en       <= w_rd_en_nxt;
            r_tx_data     <= w_tx_data_nxt;
            r_tx_start    <= w_tx_start_nxt;
            r_busy        <= w_busy_nxt;
            r_bytes_sent  <= w_bytes_sent_nxt;
            r_xfer_done   <= w_xfer_done_nxt;
            r_timeout_err <= w_timeout_err_nxt;
        end
    end

    assign mem_read_addr     = r_rd_addr;
    assign mem_read_enable   = r_rd_en;
    assign uart_tx_data      = r_tx_data;
    assign uart_tx_start     = r_tx_start;
    assign busy              = r_busy;
    assign bytes_sent        = r_bytes_sent;
    assign transmission_done = r_xfer_done;
    assign timeout_err       = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_stream_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_stream_ctrl
// Description : Scoreboard bench for uart_tx_stream_ctrl: memory model,
//               uart_tx responder, transfer-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_stream_ctrl;

    localparam int ADDR_W         = 4;
    localparam int DATA_W         = 8;
    localparam int MAX_BYTES      = 16;
    localparam int RD_LATENCY     = 3;
    localparam int GAP_CYCLES     = 2;
    localparam int TIMEOUT_CYCLES = 50;
    localparam int CNT_W          = $clog2(MAX_BYTES + 1);
    localparam int MEM_DEPTH      = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [CNT_W-1:0]  byte_count = '0;
    logic              abort = 1'b0;
    logic [ADDR_W-1:0] mem_read_addr;
    logic              mem_read_enable;
    logic [DATA_W-1:0] mem_read_data;
    logic [DATA_W-1:0] uart_tx_data;
    logic              uart_tx_start;
    logic              uart_tx_done = 1'b0;
    logic              busy;
    logic [CNT_W-1:0]  bytes_sent;
    logic              transmission_done;
    logic              timeout_err;

    always #5 clk = ~clk;

    uart_tx_stream_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BYTES(MAX_BYTES),
        .RD_LATENCY(RD_LATENCY), .GAP_CYCLES(GAP_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr),
        .byte_count(byte_count), .abort(abort), .mem_read_addr(mem_read_addr),
        .mem_read_enable(mem_read_enable), .mem_read_data(mem_read_data),
        .uart_tx_data(uart_tx_data), .uart_tx_start(uart_tx_start),
        .uart_tx_done(uart_tx_done), .busy(busy), .bytes_sent(bytes_sent),
        .transmission_done(transmission_done), .timeout_err(timeout_err)
    );

    // Memory with RD_LATENCY-cycle read pipeline; junk when not strobed.
    logic [DATA_W-1:0] mem     [MEM_DEPTH];
    logic [DATA_W-1:0] rd_pipe [RD_LATENCY];
    always @(posedge clk) begin
        rd_pipe[0] <= mem_read_enable ? mem[mem_read_addr] : DATA_W'($urandom);
        for (int i = 1; i < RD_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_read_data = rd_pipe[RD_LATENCY-1];

    // Scoreboard
    typedef struct {
        logic [CNT_W-1:0] sent;
        logic             terr;
        logic             tmo;
    } done_t;

    logic [ADDR_W-1:0] exp_addr[$];
    logic [DATA_W-1:0] exp_data[$];
    done_t             exp_done[$];
    int checks = 0;
    int errors = 0;

    // Responder configuration (byte index to stall / abort on, delay range)
    int sup_idx   = -1;
    int abt_idx   = -1;
    int resp_dmin = 0;
    int resp_dmax = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // uart_tx responder: answers each start pulse with done after a delay.
    initial begin : responder
        int cd = 0;
        int cur = 0;
        int byte_no = 0;
        bit pending = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            uart_tx_done = 1'b0;
            abort        = 1'b0;
            if (!rstn || !busy) begin
                pending = 1'b0;
                byte_no = 0;
            end
            if (uart_tx_start) begin
                pending = 1'b1;
                cd      = $urandom_range(resp_dmax, resp_dmin);
                cur     = byte_no;
                byte_no++;
            end
            if (pending) begin
                if (cur == sup_idx) begin
                    uart_tx_done = 1'b0;
                end else if (cd == 0) begin
                    uart_tx_done = 1'b1;
                    abort        = (cur == abt_idx);
                    pending      = 1'b0;
                end else begin
                    cd--;
                end
            end else begin
                uart_tx_done = ($urandom_range(5, 0) == 0);
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a read, a byte or a done.
    initial begin : monitor
        int cyc = 0;
        int rd_cyc = -100;
        int st_cyc = -100;
        int dn_cyc = 0;
        bit in_wait = 1'b0;
        bit gap_arm = 1'b0;
        bit prev_en = 1'b0;
        done_t d;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rstn) begin
                in_wait = 1'b0;
                gap_arm = 1'b0;
                prev_en = 1'b0;
                continue;
            end
            if (mem_read_enable) begin
                check("rd_strobe_single_cycle", 32'(prev_en), 32'd0);
                if (exp_addr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_read: addr %0h, no read expected", mem_read_addr);
                end else begin
                    check("rd_addr", 32'(mem_read_addr), 32'(exp_addr.pop_front()));
                end
                if (gap_arm) begin
                    check("done_to_read_cycles", 32'(cyc - dn_cyc), 32'(GAP_CYCLES + 1));
                    gap_arm = 1'b0;
                end
                rd_cyc = cyc;
            end
            prev_en = mem_read_enable;
            if (uart_tx_start) begin
                check("read_to_start_cycles", 32'(cyc - rd_cyc), 32'(1 + RD_LATENCY));
                if (exp_data.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_tx_start: data %0h, no byte expected", uart_tx_data);
                end else begin
                    check("tx_data", 32'(uart_tx_data), 32'(exp_data.pop_front()));
                end
                in_wait = 1'b1;
                st_cyc  = cyc;
            end
            if (in_wait && uart_tx_done) begin
                in_wait = 1'b0;
                gap_arm = !abort;
                dn_cyc  = cyc;
            end
            if (transmission_done) begin
                gap_arm = 1'b0;
                if (exp_done.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: bytes_sent %0d, no done expected", bytes_sent);
                end else begin
                    d = exp_done.pop_front();
                    check("done_bytes_sent", 32'(bytes_sent), 32'(d.sent));
                    check("done_timeout_err", 32'(timeout_err), 32'(d.terr));
                    check("done_busy_low", 32'(busy), 32'd0);
                    if (d.tmo) begin
                        check("timeout_wait_cycles", 32'(cyc - st_cyc), 32'(TIMEOUT_CYCLES));
                        in_wait = 1'b0;
                    end
                end
            end
        end
    end

    // One transfer: derive the expected reads/bytes/done from the transfer rules.
    task automatic run_xfer(input int base, input int cnt, input int sup, input int abt,
                            input int dmin, input int dmax, input bit mid_start);
        int n, stop, sent, a;
        bit tmo;
        done_t d;
        n    = (cnt > MAX_BYTES) ? MAX_BYTES : cnt;
        stop = n;
        sent = n;
        tmo  = 1'b0;
        if (sup >= 0 && sup < n) begin
            stop = sup + 1; sent = sup; tmo = 1'b1;
        end else if (abt >= 0 && abt < n) begin
            stop = abt + 1; sent = abt;
        end
        for (int i = 0; i < stop; i++) begin
            a = (base + i) % MEM_DEPTH;
            exp_addr.push_back(ADDR_W'(a));
            exp_data.push_back(mem[a]);
        end
        if (tmo || !(abt >= 0 && abt < n)) begin
            d.sent = CNT_W'(sent); d.terr = tmo; d.tmo = tmo;
            exp_done.push_back(d);
        end
        sup_idx   = tmo ? sup : -1;
        abt_idx   = (!tmo && abt >= 0 && abt < n) ? abt : -1;
        resp_dmin = dmin;
        resp_dmax = dmax;

        base_addr  = ADDR_W'(base);
        byte_count = CNT_W'(cnt);
        start      = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("accept_busy", 32'(busy), 32'(n != 0));
        check("accept_timeout_cleared", 32'(timeout_err), 32'd0);
        check("accept_bytes_sent", 32'(bytes_sent), 32'd0);
        if (mid_start) begin
            tick(); tick();
            base_addr  = ADDR_W'($urandom);
            byte_count = CNT_W'($urandom_range(MAX_BYTES, 1));
            start      = 1'b1;
            tick();
            start = 1'b0;
        end
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("xfer_finishes", 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
        check("end_bytes_sent", 32'(bytes_sent), 32'(sent));
        check("end_timeout_err", 32'(timeout_err), 32'(tmo));
        check("reads_outstanding", 32'(exp_addr.size()), 32'd0);
        check("bytes_outstanding", 32'(exp_data.size()), 32'd0);
        check("dones_outstanding", 32'(exp_done.size()), 32'd0);
    endtask

    // Global time bound
    initial begin : time_guard
        #2000000;
        $display("FAIL sim_time_bound: simulation still running, expected finish");
        $fatal(1, "time bound exceeded");
    end

    // Stimulus
    initial begin : stimulus
        int b, c, m, nn, s, a;
        for (int i = 0; i < MEM_DEPTH; i++) mem[i] = DATA_W'($urandom);
        rstn = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rd_en", 32'(mem_read_enable), 32'd0);
        check("rst_tx_start", 32'(uart_tx_start), 32'd0);
        check("rst_done", 32'(transmission_done), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        check("rst_bytes_sent", 32'(bytes_sent), 32'd0);
        tick();
        rstn = 1'b1;
        tick();

        // Basic message, done 10 cycles after each start pulse
        mem[0] = 8'h48; mem[1] = 8'h65; mem[2] = 8'h6C; mem[3] = 8'h6C;
        run_xfer(0, 4, -1, -1, 10, 10, 1'b0);
        // Latency/gap with short random handshakes
        run_xfer(9, 2, -1, -1, 0, 3, 1'b0);
        // Address wrap and count clamp
        run_xfer(14, 20, -1, -1, 0, 2, 1'b0);
        // Zero count
        run_xfer(3, 0, -1, -1, 0, 0, 1'b0);
        // Start while busy is ignored
        run_xfer(5, 3, -1, -1, 0, 2, 1'b1);
        // Watchdog on byte 2, then the next start clears timeout_err
        run_xfer(2, 3, 1, -1, 0, 3, 1'b0);
        run_xfer(8, 1, -1, -1, 0, 1, 1'b0);
        // Abort together with done of byte 2
        run_xfer(6, 4, -1, 1, 0, 3, 1'b0);

        // Reset during LATENCY
        exp_addr.push_back(ADDR_W'(5));
        sup_idx = -1; abt_idx = -1; resp_dmin = 0; resp_dmax = 0;
        base_addr = ADDR_W'(5); byte_count = CNT_W'(3); start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (mem_read_enable) break;
        end
        tick();
        rstn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_rd_en", 32'(mem_read_enable), 32'd0);
        check("midrst_rd_addr", 32'(mem_read_addr), 32'd0);
        check("midrst_tx_data", 32'(uart_tx_data), 32'd0);
        check("midrst_tx_start", 32'(uart_tx_start), 32'd0);
        check("midrst_bytes_sent", 32'(bytes_sent), 32'd0);
        check("midrst_done", 32'(transmission_done), 32'd0);
        tick(); tick();
        rstn = 1'b1;
        repeat (12) @(negedge clk);
        check("midrst_reads_outstanding", 32'(exp_addr.size()), 32'd0);
        check("midrst_idle", 32'(busy), 32'd0);

        // Randomized transfers
        for (int t = 0; t < 14; t++) begin
            b  = $urandom_range(MEM_DEPTH - 1, 0);
            c  = $urandom_range(MAX_BYTES + 4, 0);
            m  = $urandom_range(4, 0);
            nn = (c > MAX_BYTES) ? MAX_BYTES : c;
            s  = -1;
            a  = -1;
            if (m == 1 && nn > 0) s = $urandom_range(nn - 1, 0);
            if (m == 2 && nn > 0) a = $urandom_range(nn - 1, 0);
            run_xfer(b, c, s, a, 0, 4, (m == 3 && nn > 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
